// File: rtl/demux4_pkg.sv
// Shared types and defaults for the four-way round-robin dispatcher.
package demux4_pkg;

  localparam int unsigned DefaultWidth   = 8;
  localparam int unsigned DefaultTimeout = 4;

  typedef logic [1:0] chan_idx_t;

  typedef enum logic {RUN, WAIT} state_t;

  function automatic chan_idx_t next_chan(input chan_idx_t c);
    return c + 2'd1;
  endfunction

endpackage

// File: rtl/out_slot.sv
// One-entry output register with valid flag; a same-cycle drain frees it for a refill.
module out_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             drain_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             free_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  always_comb begin
    valid_d = load_i || (valid_q && !drain_i);
    // Data holds its last value after a drain.
    data_d  = load_i ? data_i : data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign free_o  = !valid_q || drain_i;

endmodule

// File: rtl/demux4_dispatcher.sv
// Round-robin dispatcher of one input stream into four one-entry channels, skipping
// a channel that stays blocked for TIMEOUT wait cycles.
module demux4_dispatcher
  import demux4_pkg::*;
#(
  parameter int unsigned WIDTH   = DefaultWidth,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] X,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] OUT1,
  output logic [WIDTH-1:0] OUT2,
  output logic [WIDTH-1:0] OUT3,
  output logic [WIDTH-1:0] OUT4,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [1:0]       s,
  output logic [7:0]       skip_cnt
);

  localparam logic [7:0] WaitMax = 8'(TIMEOUT - 1);

  state_t    state_q, state_d;
  chan_idx_t s_q, s_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] skip_cnt_q, skip_cnt_d;

  logic [3:0]       slot_free;
  logic [3:0]       load;
  logic [WIDTH-1:0] slot_data [4];
  logic             accept;

  assign accept = in_valid && slot_free[s_q];
  assign load   = accept ? (4'b0001 << s_q) : 4'b0000;

  for (genvar i = 0; i < 4; i++) begin : g_slot
    out_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .load_i (load[i]),
      .drain_i(out_ready[i]),
      .data_i (X),
      .data_o (slot_data[i]),
      .valid_o(out_valid[i]),
      .free_o (slot_free[i])
    );
  end

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    wait_cnt_d = wait_cnt_q;
    skip_cnt_d = skip_cnt_q;
    unique case (state_q)
      RUN: begin
        if (accept) begin
          s_d = next_chan(s_q);
        end else if (in_valid) begin
          state_d    = WAIT;
          wait_cnt_d = '0;
        end
      end
      WAIT: begin
        if (accept) begin
          state_d    = RUN;
          wait_cnt_d = '0;
          s_d        = next_chan(s_q);
        end else if (!in_valid) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WaitMax) begin
          // Give up on this channel so one stuck consumer cannot stall the rotation.
          state_d    = RUN;
          wait_cnt_d = '0;
          s_d        = next_chan(s_q);
          if (skip_cnt_q != 8'hFF) skip_cnt_d = skip_cnt_q + 8'd1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      s_q        <= '0;
      wait_cnt_q <= '0;
      skip_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      wait_cnt_q <= wait_cnt_d;
      skip_cnt_q <= skip_cnt_d;
    end
  end

  assign in_ready = slot_free[s_q];
  assign s        = s_q;
  assign skip_cnt = skip_cnt_q;
  assign OUT1     = slot_data[0];
  assign OUT2     = slot_data[1];
  assign OUT3     = slot_data[2];
  assign OUT4     = slot_data[3];

endmodule

// File: tb/tb_demux4_dispatcher.sv
// Scoreboard bench: a streak-counting reference model predicts routing, skips and
// per-channel word order; a monitor checks every drained word.
module tb_demux4_dispatcher;

  localparam int W  = 8;
  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] x;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out1, out2, out3, out4;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [1:0]   s;
  logic [7:0]   skip_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: channel occupancy, pointer, consecutive blocked-request streak.
  int           m_ptr;
  int           m_streak;
  int           m_skip;
  bit           m_occ [4];
  logic [W-1:0] exp_q [4][$];
  logic [W-1:0] out_arr [4];
  logic [W-1:0] mon_exp;

  demux4_dispatcher #(
    .WIDTH  (W),
    .TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .X        (x),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .OUT1     (out1),
    .OUT2     (out2),
    .OUT3     (out3),
    .OUT4     (out4),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s        (s),
    .skip_cnt (skip_cnt)
  );

  always #5 clk = ~clk;

  assign out_arr[0] = out1;
  assign out_arr[1] = out2;
  assign out_arr[2] = out3;
  assign out_arr[3] = out4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_ptr    = 0;
    m_streak = 0;
    m_skip   = 0;
    for (int i = 0; i < 4; i++) begin
      m_occ[i] = 1'b0;
      exp_q[i].delete();
    end
  endtask

  // Drive one cycle of inputs, check visible state, then advance the model.
  task automatic step(input logic iv, input logic [W-1:0] xv, input logic [3:0] ordy);
    bit         free_p;
    logic [3:0] occ_bits;
    @(negedge clk);
    in_valid  = iv;
    x         = xv;
    out_ready = ordy;
    #1;
    for (int i = 0; i < 4; i++) occ_bits[i] = m_occ[i];
    free_p = !m_occ[m_ptr] || ordy[m_ptr];
    check("in_ready", {31'b0, in_ready}, {31'b0, free_p});
    check("s", {30'b0, s}, m_ptr);
    check("skip_cnt", {24'b0, skip_cnt}, m_skip);
    check("out_valid", {28'b0, out_valid}, {28'b0, occ_bits});
    for (int i = 0; i < 4; i++) if (ordy[i]) m_occ[i] = 1'b0;
    if (iv && free_p) begin
      m_occ[m_ptr] = 1'b1;
      exp_q[m_ptr].push_back(xv);
      m_ptr    = (m_ptr + 1) % 4;
      m_streak = 0;
    end else if (iv) begin
      // One RUN cycle plus TIMEOUT wait cycles of blocking before the pointer moves on.
      m_streak++;
      if (m_streak == TO + 1) begin
        m_ptr    = (m_ptr + 1) % 4;
        m_streak = 0;
        if (m_skip < 255) m_skip++;
      end
    end else begin
      m_streak = 0;
    end
  endtask

  // Monitor: every drain transfer must present the oldest expected word of that channel.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL drain_ch%0d actual=%0h required=none (no word expected)", i,
                     out_arr[i]);
          end else begin
            mon_exp = exp_q[i].pop_front();
            check($sformatf("drain_ch%0d", i), {24'b0, out_arr[i]}, {24'b0, mon_exp});
          end
        end
      end
    end
  end

  task automatic reset_now();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    rst       = 1'b1;
    #1;
    check("rst_out_valid", {28'b0, out_valid}, 32'h0);
    check("rst_s", {30'b0, s}, 32'h0);
    check("rst_skip_cnt", {24'b0, skip_cnt}, 32'h0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    x         = '0;
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    model_clear();
    repeat (2) @(negedge clk);
    check("reset_out1", {24'b0, out1}, 32'h0);
    check("reset_out2", {24'b0, out2}, 32'h0);
    check("reset_out3", {24'b0, out3}, 32'h0);
    check("reset_out4", {24'b0, out4}, 32'h0);
    check("reset_out_valid", {28'b0, out_valid}, 32'h0);
    rst = 1'b0;

    // Streaming with every consumer ready.
    for (int i = 0; i < 8; i++) step(1'b1, 8'hA0 + 8'(i), 4'hF);
    repeat (2) step(1'b0, 8'h00, 4'hF);

    // Everything blocked: pointer keeps rotating and skip_cnt saturates.
    for (int i = 0; i < 4; i++) step(1'b1, 8'hB0 + 8'(i), 4'h0);
    repeat (1400) step(1'b1, 8'($urandom), 4'h0);
    repeat (2) step(1'b0, 8'h00, 4'hF);

    // Single blocked channel 0 then skip into channel 1.
    reset_now();
    step(1'b1, 8'hC0, 4'h0);
    repeat (3) step(1'b0, 8'h00, 4'b1110);
    repeat (8) step(1'b1, 8'($urandom), 4'b1110);
    step(1'b0, 8'h00, 4'hF);

    // Random traffic with sparse consumer readiness.
    for (int n = 0; n < 600; n++) begin
      logic [3:0] r;
      for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 2) == 0);
      step($urandom_range(0, 3) != 0, 8'($urandom), r);
    end
    repeat (2) step(1'b0, 8'h00, 4'hF);

    // Reset in the middle of WAIT with three channels occupied.
    for (int i = 0; i < 4; i++) step(1'b1, 8'hD0 + 8'(i), 4'h0);
    step(1'b0, 8'h00, 4'b1000);
    repeat (2) step(1'b1, 8'hEE, 4'h0);
    reset_now();
    step(1'b1, 8'h5A, 4'h0);
    step(1'b0, 8'h00, 4'h0);
    check("post_rst_out1", {24'b0, out1}, 32'h5A);
    step(1'b0, 8'h00, 4'hF);
    step(1'b0, 8'h00, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux4_dispatcher.md
DEMUX4_DISPATCHER -- requirements
Module: demux4_dispatcher

Interface
REQ-001 Parameter WIDTH, default 8, data width of X and OUT1..OUT4.
REQ-002 Parameter TIMEOUT, default 4, number of WAIT cycles before a blocked channel is skipped; legal range 1..255.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 X  input  WIDTH  input data word.
REQ-007 in_valid  input  1  X holds a valid word.
REQ-008 in_ready  output  1  the block accepts X this cycle.
REQ-009 OUT1, OUT2, OUT3, OUT4  output  WIDTH  registered channel data for channels 0..3.
REQ-010 out_valid  output  4  bit i: channel i holds a word.
REQ-011 out_ready  input  4  bit i: consumer of channel i takes its word this cycle.
REQ-012 s  output  2  current round-robin channel pointer; drives a downstream DMUX4Way select.
REQ-013 skip_cnt  output  8  saturating count of timeout skips.

Function
REQ-014 A transfer on any port SHALL occur only when its valid and ready are both high on a rising clk edge.
REQ-015 Each channel SHALL hold one entry; slot_free(i) = !out_valid[i] || out_ready[i], so a same-cycle drain allows a refill.
REQ-016 in_ready SHALL equal slot_free(s), combinationally, in both FSM states.
REQ-017 An accepted word SHALL be loaded into channel s, with out_valid[s] high from the next cycle (latency 1), and s SHALL advance by 1 modulo 4 (3 wraps to 0).
REQ-018 On a simultaneous drain and load of the same channel, out_valid SHALL stay 1 and the channel data SHALL take the new word.
REQ-019 When a channel is drained without a load, its out_valid SHALL clear next cycle and its OUTn data SHALL hold its last value.
REQ-020 FSM states: RUN and WAIT.
REQ-021 In RUN, if in_valid && !slot_free(s), the FSM SHALL go to WAIT with wait_cnt = 0.
REQ-022 In WAIT, an accept SHALL return the FSM to RUN, clear wait_cnt and advance s.
REQ-023 In WAIT, if in_valid drops, the FSM SHALL return to RUN with wait_cnt cleared and s unchanged.
REQ-024 In WAIT, if the channel is still blocked and wait_cnt == TIMEOUT-1, s SHALL advance by 1 with no accept, the FSM SHALL go to RUN and skip_cnt SHALL increment, saturating at 255.
REQ-025 Otherwise, in WAIT, wait_cnt SHALL increment by 1.
REQ-026 The skip rule SHALL apply even when all four channels are blocked, so s continues to rotate.
REQ-027 Words SHALL never be dropped, duplicated or reordered within a channel.

Reset
REQ-028 rst SHALL asynchronously force s=0, out_valid=0, OUT1..OUT4=0, FSM=RUN, wait_cnt=0 and skip_cnt=0.
REQ-029 Held words SHALL be discarded when rst is asserted mid-operation.
REQ-030 in_ready SHALL be 1 on the first cycle after rst deasserts.

Structure
REQ-031 The shared package demux4_pkg SHALL hold the FSM state enum (RUN, WAIT), the chan_idx_t 2-bit typedef and the default WIDTH/TIMEOUT constants.
REQ-032 Sub-module out_slot (one-entry register with valid, load and drain) SHALL be instantiated four times.

Verification
REQ-033 Reset, all out_ready=1, in_valid=1 with X=8'hA0..8'hA7 over 8 cycles -> OUT1..OUT4 show A0,A1,A2,A3 then A4..A7, one cycle after each accept; s cycles 0,1,2,3,0; skip_cnt=0.
REQ-034 out_ready=4'b0000, 4 words accepted, then in_valid held high -> in_ready=0; after TIMEOUT=4 WAIT cycles s advances; skip_cnt increments every 5 cycles with no further accepts.
REQ-035 TIMEOUT=4, out_valid[0]=1 and out_ready[0]=0 held, s=0, in_valid=1 from cycle 0 -> WAIT cycles 1..4, s=1 at cycle 5, word accepted at cycle 5, OUT2 valid at cycle 6, skip_cnt=1.
REQ-036 Channel 2 full, with out_ready[2]=1 and in_valid=1 in the same cycle at s=2 -> accept occurs, out_valid[2] stays 1 and OUT3 holds the new word.
REQ-037 Assert rst mid-WAIT with 3 channels full -> immediately out_valid=0, s=0 and skip_cnt=0; after release, the first word goes to OUT1.
